// File: rtl/pulse_tracer_pkg.sv
// pulse_tracer_pkg: shared definitions for the multi-channel pulse tracer.
//   MODE_*  : pulse-selection encodings for the top-level `mode` port
//   chan_state_t : per-channel debounce FSM state
//   eff_len : clamps a programmed filter length into 1..max_len
package pulse_tracer_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } chan_state_t;

    // 0 and 1 both mean "one sample"; anything above max_len saturates.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned max_len);
        if (len <= 1)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/pulse_tracer_chan.sv
// pulse_tracer_chan: one debounce channel.
//   clk, rst   : clock, synchronous active-high reset
//   noisy      : raw asynchronous input
//   len        : effective filter length, already clamped to 1..MAX_LEN
//   mode       : pulse selection (rise / fall / both / off)
//   cnt_clr    : clears the event counter (wins over an increment)
//   level      : debounced level
//   pulse      : registered one-cycle edge pulse
//   pulse_nxt  : value `pulse` takes on the next edge (lets the top
//                register an OR that lines up with `pulse`)
//   cnt        : saturating event counter
module pulse_tracer_chan
    import pulse_tracer_pkg::*;
#(
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             noisy,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             level,
    output logic             pulse,
    output logic             pulse_nxt,
    output logic [CNT_W-1:0] cnt
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    chan_state_t            state, state_nxt;
    logic [LEN_W-1:0]       run, run_nxt;
    logic                   flip;
    logic                   len_one;
    logic [LEN_W-1:0]       len_m1;
    logic                   rise_ok, fall_ok;

    assign s       = sync[SYNC_STAGES-1];
    assign len_one = (len <= LEN_W'(1));
    assign len_m1  = len - LEN_W'(1);
    assign rise_ok = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_ok = (mode == MODE_FALL) || (mode == MODE_BOTH);

    // State register, synchroniser, level/pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            state <= STABLE;
            run   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync[0] <= noisy;
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
            state <= state_nxt;
            run   <= run_nxt;
            level <= level ^ flip;
            pulse <= pulse_nxt;
        end
    end

    // Counter follows the registered pulse, so it updates one cycle later.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            cnt <= '0;
        else if (pulse && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            STABLE: if ((s != level) && !len_one) state_nxt = PEND;
            PEND:   if ((s == level) || (run >= len_m1)) state_nxt = STABLE;
            default: state_nxt = STABLE;
        endcase
    end

    // Output logic. `>=` rather than `==` so a length lowered while
    // pending flips on the very next differing sample.
    always_comb begin
        flip    = 1'b0;
        run_nxt = run;
        unique case (state)
            STABLE: begin
                run_nxt = '0;
                if (s != level) begin
                    if (len_one)
                        flip = 1'b1;
                    else
                        run_nxt = LEN_W'(1);
                end
            end
            PEND: begin
                if (s == level) begin
                    run_nxt = '0;
                end else if (run >= len_m1) begin
                    flip    = 1'b1;
                    run_nxt = '0;
                end else begin
                    run_nxt = run + LEN_W'(1);
                end
            end
            default: run_nxt = '0;
        endcase
        pulse_nxt = flip && (level ? fall_ok : rise_ok);
    end

endmodule

// File: rtl/pulse_tracer_mc.sv
// pulse_tracer_mc: multi-channel glitch filter and edge-pulse generator.
//   clk, rst   : clock, synchronous active-high reset
//   noisy_in   : raw asynchronous inputs, bit i = channel i
//   filt_len   : consecutive differing samples needed (0/1 -> 1, >MAX_LEN -> MAX_LEN)
//   mode       : 00 rise, 01 fall, 10 both, 11 pulses off
//   cnt_clr    : clears all event counters
//   level_out  : debounced levels
//   pulse_out  : one-cycle edge pulses
//   any_pulse  : OR of pulse_out, aligned with it
//   evt_cnt    : saturating counters, channel i at [i*CNT_W +: CNT_W]
module pulse_tracer_mc
    import pulse_tracer_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MAX_LEN     = 15,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            noisy_in,
    input  logic [$clog2(MAX_LEN+1)-1:0] filt_len,
    input  logic [1:0]                   mode,
    input  logic                         cnt_clr,
    output logic [NUM_CH-1:0]            level_out,
    output logic [NUM_CH-1:0]            pulse_out,
    output logic                         any_pulse,
    output logic [NUM_CH*CNT_W-1:0]      evt_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN+1);

    logic [LEN_W-1:0]  len_eff;
    logic [NUM_CH-1:0] pulse_nxt;

    assign len_eff = LEN_W'(eff_len(32'(filt_len), MAX_LEN));

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pulse_tracer_chan #(
            .LEN_W       (LEN_W),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .noisy     (noisy_in[ch]),
            .len       (len_eff),
            .mode      (mode),
            .cnt_clr   (cnt_clr),
            .level     (level_out[ch]),
            .pulse     (pulse_out[ch]),
            .pulse_nxt (pulse_nxt[ch]),
            .cnt       (evt_cnt[ch*CNT_W +: CNT_W])
        );
    end

    // Registered from the channels' next-pulse values so it rises with pulse_out.
    always_ff @(posedge clk) begin
        if (rst)
            any_pulse <= 1'b0;
        else
            any_pulse <= |pulse_nxt;
    end

endmodule

// File: tb/tb_pulse_tracer_mc.sv
// Testbench for pulse_tracer_mc (NUM_CH=4, MAX_LEN=12, SYNC_STAGES=2, CNT_W=2).
// Expected pulse cycles are pushed when an input is driven and popped by a
// per-cycle monitor; level and counter values are checked inline per task.
module tb_pulse_tracer_mc;

    localparam int unsigned NCH = 4;
    localparam int unsigned MAXL = 12;
    localparam int unsigned SYNC = 2;
    localparam int unsigned CW = 2;
    localparam int unsigned LW = $clog2(MAXL+1);

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    noisy_in;
    logic [LW-1:0]     filt_len;
    logic [1:0]        mode;
    logic              cnt_clr;
    logic [NCH-1:0]    level_out;
    logic [NCH-1:0]    pulse_out;
    logic              any_pulse;
    logic [NCH*CW-1:0] evt_cnt;

    typedef struct {
        int       cyc;
        logic [NCH-1:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   sb_en = 0;

    pulse_tracer_mc #(
        .NUM_CH      (NCH),
        .MAX_LEN     (MAXL),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .noisy_in  (noisy_in),
        .filt_len  (filt_len),
        .mode      (mode),
        .cnt_clr   (cnt_clr),
        .level_out (level_out),
        .pulse_out (pulse_out),
        .any_pulse (any_pulse),
        .evt_cnt   (evt_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: one expected pulse mask per cycle (zero if none queued).
    always begin
        logic [NCH-1:0] exp_p;
        @(posedge clk);
        #1;
        if (sb_en) begin
            exp_p = '0;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed_pulse cyc=%0d expected mask %b never checked", sb_q[0].cyc, sb_q[0].mask);
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_p = sb_q[0].mask;
                void'(sb_q.pop_front());
            end
            n_cmp++;
            if (pulse_out !== exp_p) begin
                n_fail++;
                $display("FAIL pulse_out cyc=%0d got %b expected %b", cyc, pulse_out, exp_p);
            end
            n_cmp++;
            if (any_pulse !== (|exp_p)) begin
                n_fail++;
                $display("FAIL any_pulse cyc=%0d got %b expected %b", cyc, any_pulse, |exp_p);
            end
        end
    end

    task automatic push(input int at, input logic [NCH-1:0] m);
        exp_t e;
        e.cyc  = at;
        e.mask = m;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clr_counters();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1; noisy_in = '0; filt_len = LW'(3); mode = 2'b00; cnt_clr = 1'b0;
        wait_until(3);
        n_cmp++; if (level_out !== '0) begin n_fail++; $display("FAIL reset_level got %b expected 0", level_out); end
        n_cmp++; if (pulse_out !== '0) begin n_fail++; $display("FAIL reset_pulse got %b expected 0", pulse_out); end
        n_cmp++; if (any_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_any got %b expected 0", any_pulse); end
        n_cmp++; if (evt_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %h expected 0", evt_cnt); end
        rst = 1'b0;
        sb_en = 1'b1;
        wait_until(10);
        c = cyc;
        noisy_in[0] = 1'b1;
        push(c + 5, 4'b0001);
        wait_until(c + 4);
        n_cmp++; if (level_out[0] !== 1'b0) begin n_fail++; $display("FAIL step_level_early got %b expected 0", level_out[0]); end
        wait_until(c + 5);
        n_cmp++; if (level_out[0] !== 1'b1) begin n_fail++; $display("FAIL step_level got %b expected 1", level_out[0]); end
        n_cmp++; if (evt_cnt[1:0] !== 2'd0) begin n_fail++; $display("FAIL step_cnt_lag got %0d expected 0", evt_cnt[1:0]); end
        wait_until(c + 6);
        n_cmp++; if (evt_cnt[1:0] !== 2'd1) begin n_fail++; $display("FAIL step_cnt got %0d expected 1", evt_cnt[1:0]); end
        noisy_in[0] = 1'b0;
        wait_until(c + 14);
        n_cmp++; if (level_out[0] !== 1'b0) begin n_fail++; $display("FAIL step_fall_level got %b expected 0", level_out[0]); end
    endtask

    task automatic test_glitch();
        int c;
        filt_len = LW'(4);
        clr_counters();
        c = cyc;
        noisy_in[1] = 1'b1;
        wait_until(c + 3);
        noisy_in[1] = 1'b0;
        wait_until(c + 12);
        n_cmp++; if (level_out[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_level got %b expected 0", level_out[1]); end
        n_cmp++; if (evt_cnt[3:2] !== 2'd0) begin n_fail++; $display("FAIL glitch_cnt got %0d expected 0", evt_cnt[3:2]); end
        c = cyc;
        noisy_in[1] = 1'b1;
        push(c + 6, 4'b0010);
        wait_until(c + 4);
        noisy_in[1] = 1'b0;
        wait_until(c + 7);
        n_cmp++; if (level_out[1] !== 1'b1) begin n_fail++; $display("FAIL hold4_level got %b expected 1", level_out[1]); end
        n_cmp++; if (evt_cnt[3:2] !== 2'd1) begin n_fail++; $display("FAIL hold4_cnt got %0d expected 1", evt_cnt[3:2]); end
        wait_until(c + 12);
        n_cmp++; if (level_out[1] !== 1'b0) begin n_fail++; $display("FAIL hold4_fall got %b expected 0", level_out[1]); end
    endtask

    task automatic test_modes();
        logic [1:0] mlist [4];
        int         expc  [4];
        int         c;
        mlist[0] = 2'b01; expc[0] = 1;
        mlist[1] = 2'b10; expc[1] = 2;
        mlist[2] = 2'b11; expc[2] = 0;
        mlist[3] = 2'b00; expc[3] = 1;
        filt_len = LW'(2);
        for (int i = 0; i < 4; i++) begin
            mode = mlist[i];
            clr_counters();
            c = cyc;
            noisy_in[2] = 1'b1;
            if (mlist[i] == 2'b00 || mlist[i] == 2'b10) push(c + 4, 4'b0100);
            wait_until(c + 5);
            n_cmp++; if (level_out[2] !== 1'b1) begin n_fail++; $display("FAIL mode%0d_rise_level got %b expected 1", i, level_out[2]); end
            wait_until(c + 10);
            noisy_in[2] = 1'b0;
            if (mlist[i] == 2'b01 || mlist[i] == 2'b10) push(c + 14, 4'b0100);
            wait_until(c + 20);
            n_cmp++; if (level_out[2] !== 1'b0) begin n_fail++; $display("FAIL mode%0d_fall_level got %b expected 0", i, level_out[2]); end
            n_cmp++; if (int'(evt_cnt[5:4]) != expc[i]) begin n_fail++; $display("FAIL mode%0d_cnt got %0d expected %0d", i, evt_cnt[5:4], expc[i]); end
        end
    endtask

    task automatic test_saturation();
        int c;
        mode = 2'b10;
        filt_len = LW'(1);
        clr_counters();
        c = cyc;
        for (int i = 0; i < 5; i++) begin
            wait_until(c + 4*i);
            noisy_in[3] = ~noisy_in[3];
            push(c + 4*i + 3, 4'b1000);
        end
        wait_until(c + 20);
        n_cmp++; if (evt_cnt[7:6] !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d expected 3", evt_cnt[7:6]); end
        wait_until(c + 23);
        n_cmp++; if (evt_cnt[7:6] !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d expected 3", evt_cnt[7:6]); end
        c = cyc;
        noisy_in[3] = ~noisy_in[3];
        push(c + 3, 4'b1000);
        wait_until(c + 3);
        n_cmp++; if (pulse_out[3] !== 1'b1) begin n_fail++; $display("FAIL clr_pulse got %b expected 1", pulse_out[3]); end
        cnt_clr = 1'b1;
        wait_until(c + 4);
        cnt_clr = 1'b0;
        n_cmp++; if (evt_cnt[7:6] !== 2'd0) begin n_fail++; $display("FAIL clr_prio got %0d expected 0", evt_cnt[7:6]); end
        wait_until(c + 5);
        n_cmp++; if (evt_cnt[7:6] !== 2'd0) begin n_fail++; $display("FAIL clr_lost got %0d expected 0", evt_cnt[7:6]); end
    endtask

    task automatic test_back_to_back();
        int c;
        mode = 2'b10;
        filt_len = LW'(1);
        clr_counters();
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            noisy_in[1] = ~noisy_in[1];
            push(c + i + 3, 4'b0010);
            @(negedge clk);
        end
        wait_until(c + 14);
        n_cmp++; if (level_out[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_level got %b expected 0", level_out[1]); end
        n_cmp++; if (evt_cnt[3:2] !== 2'd3) begin n_fail++; $display("FAIL b2b_cnt got %0d expected 3", evt_cnt[3:2]); end
    endtask

    task automatic test_multi();
        int c;
        mode = 2'b10;
        filt_len = LW'(3);
        @(negedge clk);
        c = cyc;
        noisy_in = '1;
        push(c + 5, 4'b1111);
        wait_until(c + 5);
        n_cmp++; if (pulse_out !== 4'b1111) begin n_fail++; $display("FAIL multi_pulse got %b expected 1111", pulse_out); end
        n_cmp++; if (any_pulse !== 1'b1) begin n_fail++; $display("FAIL multi_any got %b expected 1", any_pulse); end
        n_cmp++; if (level_out !== 4'b1111) begin n_fail++; $display("FAIL multi_level got %b expected 1111", level_out); end
        wait_until(c + 6);
        noisy_in = '0;
        push(c + 11, 4'b1111);
        wait_until(c + 14);
        n_cmp++; if (level_out !== 4'b0000) begin n_fail++; $display("FAIL multi_fall got %b expected 0000", level_out); end
    endtask

    task automatic test_reset_pend();
        int c;
        mode = 2'b00;
        filt_len = LW'(6);
        @(negedge clk);
        c = cyc;
        noisy_in[0] = 1'b1;
        wait_until(c + 5);
        rst = 1'b1;
        noisy_in[0] = 1'b0;
        wait_until(c + 6);
        rst = 1'b0;
        n_cmp++; if (level_out !== '0) begin n_fail++; $display("FAIL rstpend_level got %b expected 0", level_out); end
        n_cmp++; if (evt_cnt !== '0) begin n_fail++; $display("FAIL rstpend_cnt got %h expected 0", evt_cnt); end
        wait_until(c + 14);
        c = cyc;
        noisy_in[0] = 1'b1;
        push(c + 8, 4'b0001);
        wait_until(c + 7);
        n_cmp++; if (level_out[0] !== 1'b0) begin n_fail++; $display("FAIL rstpend_run_cleared got %b expected 0", level_out[0]); end
        wait_until(c + 8);
        n_cmp++; if (level_out[0] !== 1'b1) begin n_fail++; $display("FAIL rstpend_after got %b expected 1", level_out[0]); end
        noisy_in[0] = 1'b0;
        wait_until(c + 18);
    endtask

    task automatic test_len_edges();
        int c;
        mode = 2'b00;
        filt_len = LW'(0);
        @(negedge clk);
        c = cyc;
        noisy_in[1] = 1'b1;
        push(c + 3, 4'b0010);
        wait_until(c + 2);
        n_cmp++; if (level_out[1] !== 1'b0) begin n_fail++; $display("FAIL len0_early got %b expected 0", level_out[1]); end
        wait_until(c + 3);
        n_cmp++; if (level_out[1] !== 1'b1) begin n_fail++; $display("FAIL len0_level got %b expected 1", level_out[1]); end
        noisy_in[1] = 1'b0;
        wait_until(c + 8);
        filt_len = LW'(MAXL + 1);
        @(negedge clk);
        c = cyc;
        noisy_in[2] = 1'b1;
        push(c + 2 + MAXL, 4'b0100);
        wait_until(c + 1 + MAXL);
        n_cmp++; if (level_out[2] !== 1'b0) begin n_fail++; $display("FAIL lenmax_early got %b expected 0", level_out[2]); end
        wait_until(c + 2 + MAXL);
        n_cmp++; if (level_out[2] !== 1'b1) begin n_fail++; $display("FAIL lenmax_level got %b expected 1", level_out[2]); end
        noisy_in[2] = 1'b0;
        wait_until(c + 2 * MAXL + 6);
        n_cmp++; if (level_out[2] !== 1'b0) begin n_fail++; $display("FAIL lenmax_fall got %b expected 0", level_out[2]); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_modes();
        test_saturation();
        test_back_to_back();
        test_multi();
        test_reset_pend();
        test_len_edges();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
